spi_dbg_mem_bridge: RTL and testbench
=====================================

// Module: spi_dbg_mem_bridge
// PURPOSE
//  Command decoder between the parallel SPI slave and N_CH debug memory ports (instr/data RAM, ...).
//  Each SPI frame delivers one 32-bit command as a 1-cycle i_cmd_valid pulse.
//  The bridge assembles NB_DATA-wide words from 16-bit chunks and holds an auto-incrementing address.
//  Issues write/read strobes with parametrised read latency and supplies the next MISO word on o_tx_data.
// PARAMETERS
//  NB_DATA  32  memory word width; multiple of 16, 16..128 (NCHK = NB_DATA/16 chunks)
//  NB_ADDR  10  memory address width, 1..16
//  N_CH     2   number of memory channels, 1..16
//  RD_LAT   1   memory read latency in clocks, >=1
// PORTS
//  i_clk        in   1             clock
//  i_rst        in   1             synchronous reset, active-high
//  i_cmd_valid  in   1             1-cycle pulse: i_cmd holds a new command
//  i_cmd        in   32            command word
//  o_tx_data    out  32            word returned to SPI slave on the next frame
//  o_mem_addr   out  NB_ADDR       shared address to all channels
//  o_mem_wdata  out  NB_DATA       shared write data
//  o_mem_we     out  N_CH          one-hot write strobe
//  o_mem_re     out  N_CH          one-hot read strobe
//  i_mem_rdata  in   N_CH*NB_DATA  read data; channel k at [k*NB_DATA +: NB_DATA]
//  o_busy       out  1             operation in progress
//  o_err        out  1             sticky error flag
// BEHAVIOUR
//  Command: [31:28] OP, [27:24] ARG, [19:16] FLAGS, [15:0] PAYLOAD.
//  - OP 0 NOP: no effect.
//  - OP 1 DATA_CHUNK: wbuf chunk ARG[2:0] <= PAYLOAD.
//  - OP 2 SET_ADDR: addr <= PAYLOAD[NB_ADDR-1:0].
//  - OP 3 WRITE / OP 4 READ: use selected channel; ARG[0]=1 post-increments addr.
//  - OP 5 SELECT: ch <= ARG; tx_sel <= FLAGS[1:0]; FLAGS[2] clears wcnt; FLAGS[3] clears err.
//  - OP 6 CHUNK_SEL: tx chunk idx <= ARG[2:0].
//  - OP 7-15: ignored, set err.
//  Error cases, command ignored and err set:
//    - chunk idx >= NCHK (OP1, OP6)
//    - ARG >= N_CH on SELECT
//    - i_cmd_valid while state != IDLE
//  FSM states: IDLE, WR, RD_WAIT.
//  - Commands are accepted only at an edge where state==IDLE.
//  - WRITE: IDLE->WR.
//    - WR lasts exactly 1 cycle: o_mem_we[ch]=1, o_mem_addr=addr, o_mem_wdata=wbuf.
//    - On exit: wcnt+1 (wraps at 16 bits); addr+1 if auto.
//  - READ: IDLE->RD_WAIT; o_mem_re[ch]=1 in the first RD_WAIT cycle only.
//    - rd_buf <= i_mem_rdata[ch] at the RD_LAT-th edge after the edge that sampled o_mem_re.
//    - At that edge: ->IDLE; addr+1 if auto.
//  - o_busy = (state != IDLE); all strobes are registered and glitch-free.
//  - SET_ADDR, DATA_CHUNK and SELECT complete in the accept cycle; state stays IDLE.
//  Address increments modulo 2^NB_ADDR: 2^NB_ADDR-1 -> 0, no flag.
//  o_tx_data is registered and reflects a source change 1 clock later. tx_sel selects:
//    - 0 status: {err, busy, 2'b0, ch[3:0], 8'h0, wcnt[15:0]}
//    - 1 {zero-ext addr}
//    - 2 {16'h0, rd_buf chunk[idx]}
//    - 3 {16'h0, wbuf chunk[idx]}
//  Simultaneous events:
//    - err set and FLAGS[3] clear in the same SELECT: clear wins.
//    - A valid arriving in the cycle a WR/RD completes is rejected: state still != IDLE.
//  Reset (any time, including mid-operation), values at the next edge:
//    - state=IDLE; we/re=0; busy=0; err=0
//    - addr=0, wbuf=0, rd_buf=0, wcnt=0, ch=0, tx_sel=0, idx=0; o_tx_data=0
// STRUCTURE
//  Shared include spi_dbg_defs.vh: OP_* opcodes, TXSEL_* codes, ST_* state encodings, command field positions.
//  Sub-module dbg_chunk_reg: NCHK x 16-bit register with indexed load and indexed read; instantiated for wbuf and rd_buf.
//  FSM, read-latency counter ($clog2(RD_LAT+1) bits), address counter and tx mux live in the top.
// TESTING
//  Config for tests 1-3: NB_DATA=32, NB_ADDR=10, N_CH=2, RD_LAT=1.
//  1. Write: DATA_CHUNK 0/1 = 16'hBEEF/16'hDEAD; SET_ADDR 0x005; WRITE ch0 auto.
//     -> one cycle of we=2'b01, addr=0x005, wdata=32'hDEADBEEF; then addr=0x006; wcnt=1.
//  2. Read back: SET_ADDR 5; READ; SELECT tx_sel=2; CHUNK_SEL 1.
//     -> re pulses once; o_tx_data=32'h0000DEAD; CHUNK_SEL 0 -> 32'h0000BEEF.
//  3. Auto-increment wrap: SET_ADDR 0x3FF; WRITE auto -> addr=0x000; no err.
//  4. Errors: SELECT ARG=2 (N_CH=2), DATA_CHUNK idx 2, OP 9.
//     -> each ignored, err=1; SELECT FLAGS=4'b1000 -> err=0.
//  5. Busy collision and latency: RD_LAT=3; READ, second valid 1 cycle later.
//     -> second command rejected, err=1; busy high 4 cycles; rd_buf captured at 3rd edge after re.
//  6. Reset during RD_WAIT: i_rst=1 one cycle.
//     -> next edge: busy=0, re=0, addr=0, o_tx_data=0; a fresh READ then works normally.

Source files
------------

// File: rtl/spi_dbg_mem_bridge_pkg.sv
// spi_dbg_mem_bridge_pkg: opcodes, tx source codes, FSM states and command field positions
package spi_dbg_mem_bridge_pkg;
    localparam logic [3:0] OP_CHUNK   = 4'd1;
    localparam logic [3:0] OP_ADDR    = 4'd2;
    localparam logic [3:0] OP_WRITE   = 4'd3;
    localparam logic [3:0] OP_READ    = 4'd4;
    localparam logic [3:0] OP_SELECT  = 4'd5;
    localparam logic [3:0] OP_CSEL    = 4'd6;
    localparam logic [3:0] OP_ILLEGAL = 4'd7;

    localparam logic [1:0] TXSEL_STATUS = 2'd0;
    localparam logic [1:0] TXSEL_ADDR   = 2'd1;
    localparam logic [1:0] TXSEL_RD     = 2'd2;

    localparam int CMD_OP    = 28;
    localparam int CMD_ARG   = 24;
    localparam int CMD_FLAGS = 16;

    typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD_WAIT} state_e;
endpackage

// File: rtl/spi_dbg_mem_bridge_chunk_reg.sv
// dbg_chunk_reg: NCHK x 16-bit register with indexed chunk load, full-word load and indexed chunk read
module dbg_chunk_reg #(
    parameter int NCHK = 2,
    parameter int IW   = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_ld,
    input  logic [IW-1:0]        i_ld_idx,
    input  logic [15:0]          i_ld_data,
    input  logic                 i_ld_all,
    input  logic [NCHK*16-1:0]   i_all_data,
    input  logic [IW-1:0]        i_rd_idx,
    output logic [15:0]          o_rd_data,
    output logic [NCHK*16-1:0]   o_all
);
    logic [NCHK-1:0][15:0] r;

    always_ff @(posedge i_clk) begin
        if (i_rst) r <= '0;
        else if (i_ld_all) r <= i_all_data;
        else if (i_ld) r[i_ld_idx] <= i_ld_data;
    end

    assign o_rd_data = r[i_rd_idx];
    assign o_all     = r;
endmodule

// File: rtl/spi_dbg_mem_bridge.sv
// spi_dbg_mem_bridge: decodes SPI command words into debug memory writes/reads
// and keeps the next MISO word registered on o_tx_data.
module spi_dbg_mem_bridge #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 10,
    parameter int N_CH    = 2,
    parameter int RD_LAT  = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_cmd_valid,
    input  logic [31:0]               i_cmd,
    output logic [31:0]               o_tx_data,
    output logic [NB_ADDR-1:0]        o_mem_addr,
    output logic [NB_DATA-1:0]        o_mem_wdata,
    output logic [N_CH-1:0]           o_mem_we,
    output logic [N_CH-1:0]           o_mem_re,
    input  logic [N_CH*NB_DATA-1:0]   i_mem_rdata,
    output logic                      o_busy,
    output logic                      o_err
);
    import spi_dbg_mem_bridge_pkg::*;

    localparam int NCHK = NB_DATA / 16;
    localparam int IW   = NCHK > 1 ? $clog2(NCHK) : 1;
    localparam int CW   = $clog2(RD_LAT + 1);

    state_e             state, state_nxt;
    logic [3:0]         op, arg, flags, ch, cmd_unused;
    logic [15:0]        pay, wcnt, wb_chunk, rd_chunk;
    logic               idle, bad, good, err_clr, rd_done, auto_inc, err;
    logic [NB_ADDR-1:0] addr;
    logic [1:0]         tx_sel;
    logic [IW-1:0]      idx;
    logic [CW-1:0]      lat_cnt;
    logic [N_CH-1:0]    ch_oh, we, re;
    logic [NB_DATA-1:0] wb_all, rd_unused;
    logic [31:0]        tx, tx_src;

    assign op         = i_cmd[CMD_OP +: 4];
    assign arg        = i_cmd[CMD_ARG +: 4];
    assign flags      = i_cmd[CMD_FLAGS +: 4];
    assign pay        = i_cmd[15:0];
    assign cmd_unused = i_cmd[23:20];

    assign idle    = state == ST_IDLE;
    assign rd_done = state == ST_RD_WAIT && lat_cnt == CW'(RD_LAT);
    assign bad     = i_cmd_valid && (!idle || op >= OP_ILLEGAL
                     || ((op == OP_CHUNK || op == OP_CSEL) && 32'(arg[2:0]) >= NCHK)
                     || (op == OP_SELECT && 32'(arg) >= N_CH));
    assign good    = i_cmd_valid && !bad;
    // An error-clearing SELECT wins over the error that same SELECT raises
    assign err_clr = i_cmd_valid && idle && op == OP_SELECT && flags[3];
    assign ch_oh   = N_CH'(1) << ch;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (good) state_nxt = op == OP_WRITE ? ST_WR : op == OP_READ ? ST_RD_WAIT : ST_IDLE;
        else if (state == ST_WR || rd_done) state_nxt = ST_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err      <= 1'b0;
            we       <= '0;
            re       <= '0;
            lat_cnt  <= '0;
            addr     <= '0;
            auto_inc <= 1'b0;
            ch       <= '0;
            tx_sel   <= '0;
            idx      <= '0;
            wcnt     <= '0;
            tx       <= '0;
        end else begin
            err     <= err_clr ? 1'b0 : bad ? 1'b1 : err;
            we      <= good && op == OP_WRITE ? ch_oh : '0;
            re      <= good && op == OP_READ ? ch_oh : '0;
            lat_cnt <= state == ST_RD_WAIT ? lat_cnt + 1'b1 : '0;
            if (good && op == OP_ADDR) addr <= pay[NB_ADDR-1:0];
            else if ((state == ST_WR || rd_done) && auto_inc) addr <= addr + 1'b1;
            if (good && (op == OP_WRITE || op == OP_READ)) auto_inc <= arg[0];
            if (good && op == OP_SELECT) begin
                ch     <= arg;
                tx_sel <= flags[1:0];
            end
            wcnt <= good && op == OP_SELECT && flags[2] ? 16'd0 : state == ST_WR ? wcnt + 16'd1 : wcnt;
            if (good && op == OP_CSEL) idx <= arg[IW-1:0];
            tx <= tx_src;
        end
    end

    always_comb begin
        tx_src = {16'h0, wb_chunk};
        if (tx_sel == TXSEL_STATUS) tx_src = {err, !idle, 2'b0, ch, 8'h0, wcnt};
        else if (tx_sel == TXSEL_ADDR) tx_src = 32'(addr);
        else if (tx_sel == TXSEL_RD) tx_src = {16'h0, rd_chunk};
    end

    dbg_chunk_reg #(.NCHK(NCHK), .IW(IW)) u_wbuf (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_ld       (good && op == OP_CHUNK),
        .i_ld_idx   (arg[IW-1:0]),
        .i_ld_data  (pay),
        .i_ld_all   (1'b0),
        .i_all_data ('0),
        .i_rd_idx   (idx),
        .o_rd_data  (wb_chunk),
        .o_all      (wb_all)
    );

    dbg_chunk_reg #(.NCHK(NCHK), .IW(IW)) u_rdbuf (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_ld       (1'b0),
        .i_ld_idx   ('0),
        .i_ld_data  ('0),
        .i_ld_all   (rd_done),
        .i_all_data (i_mem_rdata[32'(ch) * NB_DATA +: NB_DATA]),
        .i_rd_idx   (idx),
        .o_rd_data  (rd_chunk),
        .o_all      (rd_unused)
    );

    assign o_tx_data   = tx;
    assign o_mem_addr  = addr;
    assign o_mem_wdata = wb_all;
    assign o_mem_we    = we;
    assign o_mem_re    = re;
    assign o_busy      = !idle;
    assign o_err       = err;
endmodule

// File: tb/tb_spi_dbg_mem_bridge.sv
// tb_spi_dbg_mem_bridge: two bridges (RD_LAT 1 and 3) against latency-accurate memory models;
// memory strobes go through a scoreboard, register views are checked directly.
module tb_spi_dbg_mem_bridge;
    typedef struct packed {
        logic        wr;
        logic [1:0]  mask;
        logic [9:0]  addr;
        logic [31:0] wdata;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cmd;
    logic [1:0]  cv, busy, err;
    logic [31:0] tx [2];
    logic [9:0]  maddr [2];
    logic [31:0] wdata [2];
    logic [1:0]  we [2];
    logic [1:0]  re [2];
    logic [63:0] rdata [2];
    ev_t         q0[$];
    ev_t         q1[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          bcnt = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = g == 0 ? 1 : 3;
        logic [31:0] mem [2][1024];
        logic [63:0] pipe [LAT];
        logic        pv [LAT];

        spi_dbg_mem_bridge #(.NB_DATA(32), .NB_ADDR(10), .N_CH(2), .RD_LAT(LAT)) u_dut (
            .i_clk       (clk),
            .i_rst       (rst),
            .i_cmd_valid (cv[g]),
            .i_cmd       (cmd),
            .o_tx_data   (tx[g]),
            .o_mem_addr  (maddr[g]),
            .o_mem_wdata (wdata[g]),
            .o_mem_we    (we[g]),
            .o_mem_re    (re[g]),
            .i_mem_rdata (rdata[g]),
            .o_busy      (busy[g]),
            .o_err       (err[g])
        );

        // Read data is valid only in the cycle before the RD_LAT-th edge after re was sampled
        always @(posedge clk) begin
            if (we[g][0]) mem[0][maddr[g]] <= wdata[g];
            if (we[g][1]) mem[1][maddr[g]] <= wdata[g];
            pv[0]   <= |re[g];
            pipe[0] <= {mem[1][maddr[g]], mem[0][maddr[g]]};
            for (int k = 1; k < LAT; k++) begin
                pv[k]   <= pv[k-1];
                pipe[k] <= pipe[k-1];
            end
        end
        assign rdata[g] = pv[LAT-1] ? pipe[LAT-1] : {2{32'hBAD0_BAD0}};
    end

    function automatic logic [31:0] c(input logic [3:0] op, input logic [3:0] arg,
                                      input logic [3:0] fl, input logic [15:0] pay);
        return {op, arg, 4'h0, fl, pay};
    endfunction

    task automatic send(input logic [1:0] m, input logic [31:0] cw);
        cmd = cw;
        cv  = m;
        @(posedge clk);
        #1;
        cv = 2'b00;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_idle(input logic [1:0] m);
        for (int i = 0; i < 20 && (busy & m) != 2'b00; i++) tick(1);
        chk("idle_timeout", 32'(busy & m), 32'h0);
    endtask

    task automatic push(input int g, input logic wr, input logic [1:0] mk,
                        input logic [9:0] a, input logic [31:0] d);
        ev_t e;
        e = {wr, mk, a, d};
        if (g == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic cmp(input int g, input ev_t e);
        logic ok;
        ok = e.wr ? (we[g] === e.mask && re[g] === 2'b00 && wdata[g] === e.wdata)
                  : (re[g] === e.mask && we[g] === 2'b00);
        ok = ok && maddr[g] === e.addr;
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL strobe dut%0d: got we=%b re=%b addr=%h wdata=%h expected wr=%b mask=%b addr=%h wdata=%h",
                     g, we[g], re[g], maddr[g], wdata[g], e.wr, e.mask, e.addr, e.wdata);
        end
    endtask

    task automatic unexpected(input int g);
        n_chk++;
        n_err++;
        $display("FAIL strobe dut%0d: unexpected we=%b re=%b addr=%h", g, we[g], re[g], maddr[g]);
    endtask

    always @(negedge clk) begin
        if (we[0] != 2'b00 || re[0] != 2'b00) begin
            if (q0.size() == 0) unexpected(0);
            else cmp(0, q0.pop_front());
        end
        if (we[1] != 2'b00 || re[1] != 2'b00) begin
            if (q1.size() == 0) unexpected(1);
            else cmp(1, q1.pop_front());
        end
        if (busy[1]) bcnt++;
    end

    initial begin
        rst = 1'b1;
        cv  = 2'b00;
        cmd = 32'h0;
        tick(3);
        chk("rst_tx0", tx[0], 32'h0);
        chk("rst_tx1", tx[1], 32'h0);
        chk("rst_busy_err", {28'h0, busy, err}, 32'h0);
        chk("rst_strobes", {24'h0, we[1], we[0], re[1], re[0]}, 32'h0);
        rst = 1'b0;

        send(2'b11, c(4'd1, 4'd0, 4'h0, 16'hBEEF));
        send(2'b11, c(4'd1, 4'd1, 4'h0, 16'hDEAD));
        send(2'b11, c(4'd2, 4'd0, 4'h0, 16'h0005));
        push(0, 1'b1, 2'b01, 10'h005, 32'hDEADBEEF);
        push(1, 1'b1, 2'b01, 10'h005, 32'hDEADBEEF);
        send(2'b11, c(4'd3, 4'd1, 4'h0, 16'h0));
        wait_idle(2'b11);
        chk("wr_addr_inc", 32'(maddr[0]), 32'h006);
        send(2'b11, c(4'd5, 4'd0, 4'h1, 16'h0));
        tick(1);
        chk("wr_tx_addr0", tx[0], 32'h006);
        chk("wr_tx_addr1", tx[1], 32'h006);
        send(2'b11, c(4'd5, 4'd0, 4'h0, 16'h0));
        tick(1);
        chk("wr_status_wcnt", tx[0], 32'h0000_0001);

        send(2'b11, c(4'd2, 4'd0, 4'h0, 16'h0005));
        push(0, 1'b0, 2'b01, 10'h005, 32'h0);
        push(1, 1'b0, 2'b01, 10'h005, 32'h0);
        send(2'b11, c(4'd4, 4'd0, 4'h0, 16'h0));
        wait_idle(2'b11);
        send(2'b11, c(4'd5, 4'd0, 4'h2, 16'h0));
        send(2'b11, c(4'd6, 4'd1, 4'h0, 16'h0));
        tick(1);
        chk("rd_chunk1_lat1", tx[0], 32'h0000_DEAD);
        chk("rd_chunk1_lat3", tx[1], 32'h0000_DEAD);
        send(2'b11, c(4'd6, 4'd0, 4'h0, 16'h0));
        tick(1);
        chk("rd_chunk0_lat1", tx[0], 32'h0000_BEEF);
        chk("rd_chunk0_lat3", tx[1], 32'h0000_BEEF);
        send(2'b11, c(4'd5, 4'd0, 4'h1, 16'h0));
        tick(1);
        chk("rd_no_auto", tx[0], 32'h005);

        send(2'b11, c(4'd2, 4'd0, 4'h0, 16'h03FF));
        push(0, 1'b1, 2'b01, 10'h3FF, 32'hDEADBEEF);
        push(1, 1'b1, 2'b01, 10'h3FF, 32'hDEADBEEF);
        send(2'b11, c(4'd3, 4'd1, 4'h0, 16'h0));
        wait_idle(2'b11);
        tick(1);
        chk("wrap_addr", tx[0], 32'h000);
        chk("wrap_no_err", 32'(err), 32'h0);
        send(2'b11, c(4'd5, 4'd0, 4'h0, 16'h0));
        tick(1);
        chk("wrap_wcnt", tx[0], 32'h0000_0002);

        send(2'b11, c(4'd5, 4'd2, 4'h1, 16'h0));
        chk("err_bad_ch", 32'(err), 32'h3);
        tick(1);
        chk("err_sel_ignored", tx[0], 32'h8000_0002);
        send(2'b11, c(4'd5, 4'd0, 4'h8, 16'h0));
        chk("err_clear", 32'(err), 32'h0);
        send(2'b11, c(4'd1, 4'd2, 4'h0, 16'h1234));
        chk("err_bad_chunk", 32'(err), 32'h3);
        send(2'b11, c(4'd5, 4'd2, 4'h8, 16'h0));
        chk("err_clear_wins", 32'(err), 32'h0);
        send(2'b11, c(4'd9, 4'd0, 4'h0, 16'h0));
        chk("err_bad_op", 32'(err), 32'h3);
        send(2'b11, c(4'd5, 4'd0, 4'hB, 16'h0));
        send(2'b11, c(4'd6, 4'd2, 4'h0, 16'h0));
        chk("err_bad_csel", 32'(err), 32'h3);
        tick(1);
        chk("err_idx_kept", tx[0], 32'h0000_BEEF);
        send(2'b11, c(4'd5, 4'd1, 4'hC, 16'h0));
        tick(1);
        chk("sel_ch1_wcnt_clr", tx[0], 32'h0100_0000);
        push(0, 1'b1, 2'b10, 10'h000, 32'hDEADBEEF);
        push(1, 1'b1, 2'b10, 10'h000, 32'hDEADBEEF);
        send(2'b11, c(4'd3, 4'd0, 4'h0, 16'h0));
        wait_idle(2'b11);
        tick(1);
        chk("ch1_write_status", tx[1], 32'h0100_0001);

        push(1, 1'b0, 2'b10, 10'h000, 32'h0);
        bcnt = 0;
        send(2'b10, c(4'd4, 4'd1, 4'h0, 16'h0));
        send(2'b10, c(4'd2, 4'd0, 4'h0, 16'h0123));
        chk("busy_reject_err", 32'(err), 32'h2);
        wait_idle(2'b10);
        chk("busy_cycles", 32'(bcnt), 32'd4);
        send(2'b10, c(4'd5, 4'd1, 4'hA, 16'h0));
        send(2'b10, c(4'd6, 4'd1, 4'h0, 16'h0));
        tick(1);
        chk("lat3_capture", tx[1], 32'h0000_DEAD);
        send(2'b10, c(4'd5, 4'd1, 4'h1, 16'h0));
        tick(1);
        chk("lat3_auto_addr", tx[1], 32'h001);

        send(2'b11, c(4'd2, 4'd0, 4'h0, 16'h00AB));
        push(0, 1'b0, 2'b10, 10'h0AB, 32'h0);
        push(1, 1'b0, 2'b10, 10'h0AB, 32'h0);
        send(2'b11, c(4'd4, 4'd0, 4'h0, 16'h0));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst_busy_err", {28'h0, busy, err}, 32'h0);
        chk("mid_rst_re", {28'h0, re[1], re[0]}, 32'h0);
        chk("mid_rst_addr", 32'(maddr[1]), 32'h0);
        chk("mid_rst_tx0", tx[0], 32'h0);
        chk("mid_rst_tx1", tx[1], 32'h0);
        send(2'b11, c(4'd5, 4'd0, 4'h2, 16'h0));
        tick(1);
        chk("mid_rst_rdbuf", tx[1], 32'h0);
        send(2'b11, c(4'd2, 4'd0, 4'h0, 16'h0005));
        push(0, 1'b0, 2'b01, 10'h005, 32'h0);
        push(1, 1'b0, 2'b01, 10'h005, 32'h0);
        send(2'b11, c(4'd4, 4'd0, 4'h0, 16'h0));
        wait_idle(2'b11);
        tick(1);
        chk("post_rst_read0", tx[0], 32'h0000_BEEF);
        chk("post_rst_read1", tx[1], 32'h0000_BEEF);

        tick(2);
        chk("sb_drain0", 32'(q0.size()), 32'h0);
        chk("sb_drain1", 32'(q1.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
